// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pc_gen_pkg: shared address type, PC generator states and fetch constants
package fetch_pc_gen_pkg;
    typedef logic [31:0] addr_t;
    typedef enum logic [1:0] {BOOT, RUN, TRAP} pcgen_state_e;
    localparam addr_t RESET_PC    = 32'h8000_0000;
    localparam addr_t INSTR_BYTES = 32'd4;
endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: exec redirect inputs and fetch handshake of the PC generator
interface fetch_pc_gen_if;
    import fetch_pc_gen_pkg::*;
    logic  res_valid;
    logic  res_br_valid;
    addr_t res_br_target;
    logic  fetch_valid;
    logic  fetch_ready;
    addr_t fetch_pc;
    logic  flush;
    logic  misalign_trap;
    modport master (
        input  res_valid, res_br_valid, res_br_target, fetch_ready,
        output fetch_valid, fetch_pc, flush, misalign_trap
    );
    modport slave (
        output res_valid, res_br_valid, res_br_target, fetch_ready,
        input  fetch_valid, fetch_pc, flush, misalign_trap
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: sequential fetch PC with registered branch redirect, flush and misalign trap
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter addr_t RESET_PC_P = RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_pc_gen_if.master       pcg_io
);
    pcgen_state_e state_q, state_d;
    addr_t        pc_q, pc_d;
    logic         flush_q, flush_d;
    logic         redir;
    always_comb begin
        redir   = pcg_io.res_valid && pcg_io.res_br_valid && state_q != TRAP;
        state_d = state_q == TRAP ? TRAP : RUN;
        pc_d    = (state_q == RUN && pcg_io.fetch_ready) ? pc_q + INSTR_BYTES : pc_q;
        flush_d = 1'b0;
        if (redir) begin
            // a misaligned target still flushes and is kept in pc for debug
            pc_d    = pcg_io.res_br_target;
            flush_d = 1'b1;
            state_d = pcg_io.res_br_target[1:0] != 2'b00 ? TRAP : RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC_P;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end
    assign pcg_io.fetch_valid   = state_q == RUN;
    assign pcg_io.fetch_pc      = pc_q;
    assign pcg_io.flush         = flush_q;
    assign pcg_io.misalign_trap = state_q == TRAP;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed checks of fetch sequencing, stalls, redirects, wrap and trap
module tb_fetch_pc_gen;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    fetch_pc_gen_if pcg_if ();
    fetch_pc_gen dut (.clk(clk), .rst(rst), .pcg_io(pcg_if.master));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc, input logic f, input logic t);
        check({tag, ".valid"}, {31'd0, pcg_if.fetch_valid}, {31'd0, v});
        check({tag, ".pc"}, pcg_if.fetch_pc, pc);
        check({tag, ".flush"}, {31'd0, pcg_if.flush}, {31'd0, f});
        check({tag, ".trap"}, {31'd0, pcg_if.misalign_trap}, {31'd0, t});
    endtask
    task automatic redir(input logic [31:0] tgt);
        pcg_if.res_valid = 1'b1;
        pcg_if.res_br_valid = 1'b1;
        pcg_if.res_br_target = tgt;
    endtask
    task automatic no_redir();
        pcg_if.res_valid = 1'b0;
        pcg_if.res_br_valid = 1'b0;
        pcg_if.res_br_target = 32'h0;
    endtask
    initial begin
        rst = 1'b0;
        pcg_if.fetch_ready = 1'b1;
        no_redir();
        step();
        step();
        expect_out("reset", 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        expect_out("boot_done", 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_out("seq", 1'b1, 32'h8000_0000 + 32'(i * 4), 1'b0, 1'b0);
        end
        pcg_if.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("stall", 1'b1, 32'h8000_0010, 1'b0, 1'b0);
        end
        pcg_if.fetch_ready = 1'b1;
        step();
        expect_out("resume", 1'b1, 32'h8000_0014, 1'b0, 1'b0);
        redir(32'h8000_1000);
        step();
        expect_out("redir", 1'b1, 32'h8000_1000, 1'b1, 1'b0);
        no_redir();
        step();
        expect_out("redir_next", 1'b1, 32'h8000_1004, 1'b0, 1'b0);
        redir(32'h8000_2000);
        step();
        expect_out("b2b_a", 1'b1, 32'h8000_2000, 1'b1, 1'b0);
        redir(32'h8000_3000);
        step();
        expect_out("b2b_b", 1'b1, 32'h8000_3000, 1'b1, 1'b0);
        no_redir();
        step();
        expect_out("b2b_next", 1'b1, 32'h8000_3004, 1'b0, 1'b0);
        pcg_if.fetch_ready = 1'b0;
        pcg_if.res_valid = 1'b0;
        pcg_if.res_br_valid = 1'b1;
        pcg_if.res_br_target = 32'h8000_5000;
        step();
        expect_out("br_no_valid", 1'b1, 32'h8000_3004, 1'b0, 1'b0);
        no_redir();
        pcg_if.fetch_ready = 1'b1;
        redir(32'hFFFF_FFFC);
        step();
        expect_out("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        no_redir();
        step();
        expect_out("wrap", 1'b1, 32'h0000_0000, 1'b0, 1'b0);
        redir(32'h8000_1002);
        step();
        expect_out("misalign", 1'b0, 32'h8000_1002, 1'b1, 1'b1);
        no_redir();
        step();
        expect_out("trap", 1'b0, 32'h8000_1002, 1'b0, 1'b1);
        redir(32'h8000_4000);
        step();
        expect_out("trap_ignore", 1'b0, 32'h8000_1002, 1'b0, 1'b1);
        rst = 1'b0;
        step();
        expect_out("rst_mid", 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        rst = 1'b1;
        no_redir();
        step();
        expect_out("restart", 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        step();
        expect_out("restart_seq", 1'b1, 32'h8000_0004, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
